// File: rtl/mips_pkg.sv
// Shared pipeline definitions: opcode classes, instruction field positions,
// memory-stage FSM encoding and branch-target arithmetic.
package mips_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int OFFSET_W = 20;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // Word offset relative to PC+4; the sum wraps at 32 bits.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [OFFSET_W-1:0] off);
    return pc + 32'd4 + {10'b0, off, 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory stage bundle plus the MEM/WB outputs and stall/branch feedback.
// master = upstream/observer side, slave = the memory stage itself.
interface mem_stage_if;
  logic        InValid;
  logic [31:0] Instruction;
  logic [31:0] PCInput;
  logic [31:0] Result;
  logic [31:0] SecOperand;
  logic        ZeroFlag;

  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        AlignFault;
  logic        WBValid;
  logic        WBWrite;
  logic [31:0] WBData;
  logic [31:0] WBInstruction;

  modport master (
    output InValid, Instruction, PCInput, Result, SecOperand, ZeroFlag,
    input  Stall, BranchTaken, BranchTarget, AlignFault,
           WBValid, WBWrite, WBData, WBInstruction
  );

  modport slave (
    input  InValid, Instruction, PCInput, Result, SecOperand, ZeroFlag,
    output Stall, BranchTaken, BranchTarget, AlignFault,
           WBValid, WBWrite, WBData, WBInstruction
  );
endinterface

// File: rtl/data_mem.sv
// Single-port word RAM: write at the edge, registered read (data valid the cycle after re).
// No backpressure; contents are not reset.
module data_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_dat,
  output logic [31:0]   rd_dat
);

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] rd_dat_q, rd_dat_d;

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (re) rd_dat_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_dat;
    rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: word load/store, branch resolution, registered MEM/WB bundle.
// Latency 1 cycle (ALU/SW/branch), 2 cycles for LW with Stall held during the read cycle.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = 256  // must be a power of two
) (
  input logic        ClockInput,
  input logic        ResetInput,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t      state_q, state_d;
  logic        branch_taken_q, branch_taken_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        align_fault_q, align_fault_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_write_q, wb_write_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_instr_q, wb_instr_d;
  logic [31:0] ld_instr_q, ld_instr_d;

  logic [5:0]    opcode;
  logic          is_lw, is_sw, is_br, taken, misaligned, accept;
  logic          mem_we, mem_re;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rd_dat;
  logic          unused_bits;

  assign opcode     = bus.Instruction[OPC_HI:OPC_LO];
  assign is_lw      = (opcode == OP_LW);
  assign is_sw      = (opcode == OP_SW);
  assign is_br      = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign taken      = ((opcode == OP_BEQ) &&  bus.ZeroFlag) ||
                      ((opcode == OP_BNE) && !bus.ZeroFlag);
  assign misaligned = (is_lw || is_sw) && (bus.Result[1:0] != 2'b00);
  assign accept     = bus.InValid && (state_q == IDLE);
  // Upper address bits are dropped, so byte addresses wrap modulo MEM_DEPTH*4.
  assign word_idx   = bus.Result[AW+1:2];
  assign mem_we     = accept && is_sw && !misaligned;
  assign mem_re     = accept && is_lw && !misaligned;
  assign unused_bits = ^{bus.Instruction[25:OFFSET_W], bus.Result[31:AW+2]};

  data_mem #(.MEM_DEPTH(MEM_DEPTH)) u_data_mem (
    .clk    (ClockInput),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (word_idx),
    .wr_dat (bus.SecOperand),
    .rd_dat (mem_rd_dat)
  );

  always_comb begin
    state_d         = state_q;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target_q;
    align_fault_d   = align_fault_q;
    wb_valid_d      = 1'b0;
    wb_write_d      = 1'b0;
    wb_data_d       = wb_data_q;
    wb_instr_d      = wb_instr_q;
    ld_instr_d      = ld_instr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mem_re) begin
            // Bundle is built next cycle from the RAM output.
            state_d    = LOAD_WAIT;
            ld_instr_d = bus.Instruction;
          end else begin
            wb_valid_d = 1'b1;
            wb_instr_d = bus.Instruction;
            wb_data_d  = 32'h0;
            if (misaligned) begin
              align_fault_d = 1'b1;
            end else if (is_br) begin
              if (taken) begin
                branch_taken_d  = 1'b1;
                branch_target_d = branch_target(bus.PCInput,
                                                bus.Instruction[OFFSET_W-1:0]);
              end
            end else if (!is_sw) begin
              wb_write_d = 1'b1;
              wb_data_d  = bus.Result;
            end
          end
        end
      end
      LOAD_WAIT: begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_write_d = 1'b1;
        wb_data_d  = mem_rd_dat;
        wb_instr_d = ld_instr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state_q         <= IDLE;
      branch_taken_q  <= 1'b0;
      branch_target_q <= 32'h0;
      align_fault_q   <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_write_q      <= 1'b0;
      wb_data_q       <= 32'h0;
      wb_instr_q      <= 32'h0;
      ld_instr_q      <= 32'h0;
    end else begin
      state_q         <= state_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
      align_fault_q   <= align_fault_d;
      wb_valid_q      <= wb_valid_d;
      wb_write_q      <= wb_write_d;
      wb_data_q       <= wb_data_d;
      wb_instr_q      <= wb_instr_d;
      ld_instr_q      <= ld_instr_d;
    end
  end

  assign bus.Stall         = (state_q == LOAD_WAIT);
  assign bus.BranchTaken   = branch_taken_q;
  assign bus.BranchTarget  = branch_target_q;
  assign bus.AlignFault    = align_fault_q;
  assign bus.WBValid       = wb_valid_q;
  assign bus.WBWrite       = wb_write_q;
  assign bus.WBData        = wb_data_q;
  assign bus.WBInstruction = wb_instr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs driven and outputs sampled on the falling edge.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage_if bus ();

  mem_stage #(.MEM_DEPTH(256)) dut (
    .ClockInput (clk),
    .ResetInput (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [19:0] off);
    return {op, 6'h00, off};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] res,
                       input logic [31:0] sec, input logic [31:0] pc, input logic zf);
    bus.InValid     = 1'b1;
    bus.Instruction = instr;
    bus.Result      = res;
    bus.SecOperand  = sec;
    bus.PCInput     = pc;
    bus.ZeroFlag    = zf;
  endtask

  task automatic idle();
    bus.InValid = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_stall"},  {31'h0, bus.Stall},       32'h0);
    check({tag, "_btaken"}, {31'h0, bus.BranchTaken}, 32'h0);
    check({tag, "_btarget"}, bus.BranchTarget,        32'h0);
    check({tag, "_afault"}, {31'h0, bus.AlignFault},  32'h0);
    check({tag, "_wbvalid"},{31'h0, bus.WBValid},     32'h0);
    check({tag, "_wbwrite"},{31'h0, bus.WBWrite},     32'h0);
    check({tag, "_wbdata"},  bus.WBData,              32'h0);
    check({tag, "_wbinstr"}, bus.WBInstruction,       32'h0);
  endtask

  // Load sequence: accept edge, one stall cycle, then the bundle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] ins;
    ins = mk(6'h23, 20'h00abc);
    drive(ins, addr, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    check({tag, "_stall"},   {31'h0, bus.Stall},   32'h1);
    check({tag, "_nowb"},    {31'h0, bus.WBValid}, 32'h0);
    @(negedge clk);
    check({tag, "_wbvalid"}, {31'h0, bus.WBValid}, 32'h1);
    check({tag, "_wbwrite"}, {31'h0, bus.WBWrite}, 32'h1);
    check({tag, "_data"},    bus.WBData,           exp);
    check({tag, "_instr"},   bus.WBInstruction,    ins);
    check({tag, "_unstall"}, {31'h0, bus.Stall},   32'h0);
  endtask

  task automatic do_branch(input string tag, input logic [5:0] op, input logic [31:0] pc,
                           input logic [19:0] off, input logic zf,
                           input logic exp_taken, input logic [31:0] exp_tgt);
    drive(mk(op, off), 32'h0, 32'h0, pc, zf);
    @(negedge clk);
    idle();
    check({tag, "_taken"},   {31'h0, bus.BranchTaken}, {31'h0, exp_taken});
    check({tag, "_target"},  bus.BranchTarget,         exp_tgt);
    check({tag, "_wbvalid"}, {31'h0, bus.WBValid},     32'h1);
    check({tag, "_wbwrite"}, {31'h0, bus.WBWrite},     32'h0);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'h0, bus.BranchTaken}, 32'h0);
    check({tag, "_hold"},      bus.BranchTarget,         exp_tgt);
  endtask

  initial begin
    bus.InValid = 1'b0; bus.Instruction = 32'h0; bus.Result = 32'h0;
    bus.SecOperand = 32'h0; bus.PCInput = 32'h0; bus.ZeroFlag = 1'b0;

    repeat (2) @(negedge clk);
    reset_vals("rst");
    rst = 1'b0;

    // ALU pass-through
    drive(mk(6'h00, 20'h0), 32'h0000_1234, 32'h0, 32'h0, 1'b0);
    check("alu_stall_n", {31'h0, bus.Stall}, 32'h0);
    @(negedge clk);
    idle();
    check("alu_wbvalid", {31'h0, bus.WBValid}, 32'h1);
    check("alu_wbwrite", {31'h0, bus.WBWrite}, 32'h1);
    check("alu_data",    bus.WBData,           32'h0000_1234);
    check("alu_instr",   bus.WBInstruction,    mk(6'h00, 20'h0));
    check("alu_stall",   {31'h0, bus.Stall},   32'h0);
    @(negedge clk);
    check("alu_wbvalid_once", {31'h0, bus.WBValid}, 32'h0);

    // Store immediately followed by a load of the same word
    drive(mk(6'h2B, 20'h0), 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    check("sw_wbvalid", {31'h0, bus.WBValid}, 32'h1);
    check("sw_wbwrite", {31'h0, bus.WBWrite}, 32'h0);
    check("sw_wbdata",  bus.WBData,           32'h0);
    do_load("sw_lw", 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lw_wbvalid_once", {31'h0, bus.WBValid}, 32'h0);

    // Branches: taken/not-taken for both senses, plus 32-bit target wrap
    do_branch("beq_t",  6'h04, 32'h100,       20'h3,  1'b1, 1'b1, 32'h110);
    do_branch("beq_nt", 6'h04, 32'h300,       20'h7,  1'b0, 1'b0, 32'h110);
    do_branch("bne_t",  6'h05, 32'h200,       20'h10, 1'b0, 1'b1, 32'h244);
    do_branch("bne_nt", 6'h05, 32'h500,       20'h1,  1'b1, 1'b0, 32'h244);
    do_branch("br_wrap",6'h04, 32'hFFFF_FFF0, 20'h5,  1'b1, 1'b1, 32'h8);

    // Misaligned store leaves word 4 untouched and sets a sticky fault
    check("afault_pre", {31'h0, bus.AlignFault}, 32'h0);
    drive(mk(6'h2B, 20'h0), 32'h13, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    check("mis_sw_fault",   {31'h0, bus.AlignFault}, 32'h1);
    check("mis_sw_wbvalid", {31'h0, bus.WBValid},    32'h1);
    check("mis_sw_wbwrite", {31'h0, bus.WBWrite},    32'h0);
    do_load("mis_rb", 32'h10, 32'hDEAD_BEEF);

    // Misaligned load retires in one cycle without a write
    drive(mk(6'h23, 20'h0), 32'h11, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    check("mis_lw_stall",   {31'h0, bus.Stall},   32'h0);
    check("mis_lw_wbvalid", {31'h0, bus.WBValid}, 32'h1);
    check("mis_lw_wbwrite", {31'h0, bus.WBWrite}, 32'h0);
    @(negedge clk);
    check("afault_sticky", {31'h0, bus.AlignFault}, 32'h1);

    // Address wrap: 0x400 aliases word 0
    drive(mk(6'h2B, 20'h0), 32'h400, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    do_load("wrap", 32'h0, 32'hCAFE_F00D);

    // Reset while the load is outstanding
    drive(mk(6'h23, 20'h0), 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    check("rml_stall", {31'h0, bus.Stall}, 32'h1);
    rst = 1'b1;
    #1;
    reset_vals("rml");
    @(negedge clk);
    check("rml_nowb",  {31'h0, bus.WBValid}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rml_nowb2", {31'h0, bus.WBValid}, 32'h0);
    check("rml_idle",  {31'h0, bus.Stall},   32'h0);
    drive(mk(6'h00, 20'h0), 32'h55, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle();
    check("post_rst_wbvalid", {31'h0, bus.WBValid}, 32'h1);
    check("post_rst_data",    bus.WBData,           32'h55);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
